uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO in front of a UART transmitter. Bytes written on wr_data are
//   queued in a circular buffer. A small FSM hands the head byte to the
//   transmitter on a baud_tick. It holds tx_en for exactly one baud period,
//   then waits for the transmitter's tx_done before the next launch.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : asynchronous, active-low reset
//   baud_tick  : one-clk strobe per UART bit period
//   wr_en      : write request for wr_data
//   wr_data    : byte to enqueue
//   full       : level == DEPTH
//   empty      : level == 0
//   level      : number of stored entries
//   overflow   : sticky flag, set when a write is dropped
//   tx_data    : byte presented to the transmitter
//   tx_en      : transmit request to the transmitter
//   tx_done    : one-clk pulse from the transmitter at end of frame
//   busy       : FSM is not in IDLE
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | nothing in flight; pop the head on baud_tick when not empty
// SEND  | tx_en high, tx_data held; leave on the next baud_tick
// WAIT  | tx_en low; leave on tx_done, or one cycle after entry if tx_done
//       | already arrived during SEND (done_seen)

module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   baud_tick,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_en,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  state_t           state;
  logic             done_seen;
  logic             do_write;
  logic             do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign busy  = (state != IDLE);

  // Writes are judged against the registered full flag, so a pop in the
  // same cycle does not make room for a write that arrived while full.
  assign do_write = wr_en & ~full;

  // empty is registered, so a byte written in this very cycle cannot be
  // launched by a coincident baud_tick.
  assign do_pop = (state == IDLE) & baud_tick & ~empty;

  // Storage needs no reset: level/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      done_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // tx_done is ignored here; tx_data keeps the last launched byte.
          if (do_pop) begin
            tx_data <= mem[rd_ptr];
            tx_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          // The transmitter may report end of frame before tx_en drops.
          if (tx_done) begin
            done_seen <= 1'b1;
          end
          if (baud_tick) begin
            tx_en <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done || done_seen) begin
            done_seen <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          tx_en     <= 1'b0;
          done_seen <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Accepted writes are pushed into a
//   scoreboard queue; each rising edge of tx_en pops the queue and compares
//   the launched byte.

module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset_n;
  logic             baud_tick;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [WIDTH-1:0] tx_data;
  logic             tx_en;
  logic             tx_done;
  logic             busy;

  int               n_tests;
  int               n_fail;
  int               m_lvl;
  logic [WIDTH-1:0] exp_q[$];
  logic             prev_tx_en;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: every new launch must match the oldest accepted byte.
  always @(negedge clk) begin
    if (tx_en && !prev_tx_en) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL launch_unexpected: observed 0x%0h expected no launch", tx_data);
      end
      if (exp_q.size() != 0) begin
        chk("launch_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        m_lvl--;
      end
    end
    prev_tx_en = tx_en;
  end

  // One clock; returns just after the falling edge so outputs are settled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (m_lvl < DEPTH) begin
      exp_q.push_back(b);
      m_lvl++;
    end
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    baud_tick = 1'b1;
    cyc();
    baud_tick = 1'b0;
  endtask

  task automatic done();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
  endtask

  // Launch, hold for a baud period, drop tx_en, then answer with tx_done.
  task automatic frame();
    tick();
    cyc();
    cyc();
    tick();
    done();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_lvl      = 0;
    prev_tx_en = 1'b0;
    reset_n    = 1'b0;
    baud_tick  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    tx_done    = 1'b0;
    cyc();
    cyc();

    // Reset values
    chk("rst_tx_en",    {31'h0, tx_en},    32'h0);
    chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
    chk("rst_empty",    {31'h0, empty},    32'h1);
    chk("rst_full",     {31'h0, full},     32'h0);
    chk("rst_level",    {28'h0, level},    32'h0);
    chk("rst_busy",     {31'h0, busy},     32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // Single byte: no launch until a baud_tick follows the write
    wr(8'hAA);
    chk("single_level_after_wr", {28'h0, level}, 32'd1);
    cyc();
    cyc();
    chk("single_no_launch_wo_tick", {31'h0, tx_en}, 32'h0);
    tick();
    chk("single_tx_en", {31'h0, tx_en}, 32'h1);
    chk("single_busy",  {31'h0, busy},  32'h1);
    chk("single_level_after_pop", {28'h0, level}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("single_hold_tx_en",   {31'h0, tx_en},   32'h1);
      chk("single_hold_tx_data", {24'h0, tx_data}, 32'hAA);
    end
    tick();
    chk("single_wait_tx_en",   {31'h0, tx_en},   32'h0);
    chk("single_wait_busy",    {31'h0, busy},    32'h1);
    chk("single_wait_tx_data", {24'h0, tx_data}, 32'hAA);
    cyc();
    chk("single_wait_holds", {31'h0, busy}, 32'h1);
    done();
    chk("single_idle_busy",    {31'h0, busy},    32'h0);
    chk("single_idle_level",   {28'h0, level},   32'd0);
    chk("single_idle_tx_data", {24'h0, tx_data}, 32'hAA);

    // Ordering
    wr(8'hFF);
    wr(8'hBB);
    wr(8'hCC);
    wr(8'hB2);
    chk("order_level", {28'h0, level}, 32'd4);
    for (int i = 0; i < 4; i++) frame();
    chk("order_empty", {31'h0, empty}, 32'h1);
    chk("order_queue_drained", exp_q.size(), 32'd0);

    // Early tx_done during SEND
    wr(8'h11);
    wr(8'h22);
    tick();
    cyc();
    done();
    chk("early_still_send", {31'h0, tx_en}, 32'h1);
    tick();
    chk("early_in_wait", {31'h0, busy}, 32'h1);
    cyc();
    chk("early_wait_exit", {31'h0, busy}, 32'h0);
    cyc();
    cyc();
    chk("early_no_launch_wo_tick", {31'h0, tx_en}, 32'h0);
    tick();
    chk("early_next_launch", {31'h0, tx_en}, 32'h1);
    tick();
    done();

    // tx_done in IDLE must not shortcut the following WAIT
    done();
    chk("idle_done_ignored", {31'h0, busy}, 32'h0);
    wr(8'h5C);
    tick();
    tick();
    cyc();
    cyc();
    chk("idle_done_wait_held", {31'h0, busy}, 32'h1);
    done();
    chk("idle_done_exit", {31'h0, busy}, 32'h0);

    // Write to empty FIFO coincident with baud_tick does not launch
    wr_en     = 1'b1;
    wr_data   = 8'h33;
    baud_tick = 1'b1;
    exp_q.push_back(8'h33);
    m_lvl++;
    cyc();
    wr_en     = 1'b0;
    baud_tick = 1'b0;
    chk("wr_tick_no_launch", {31'h0, tx_en}, 32'h0);
    chk("wr_tick_level",     {28'h0, level}, 32'd1);
    cyc();
    frame();
    chk("wr_tick_empty", {31'h0, empty}, 32'h1);

    // Full / overflow: DEPTH+1 writes, last dropped
    for (int i = 0; i <= DEPTH; i++) wr(8'hC0 + 8'(i));
    chk("full_flag",     {31'h0, full},     32'h1);
    chk("full_level",    {28'h0, level},    DEPTH);
    chk("full_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < DEPTH; i++) frame();
    chk("full_drained_empty", {31'h0, empty}, 32'h1);
    tick();
    tick();
    chk("full_dropped_never_sent", {31'h0, tx_en}, 32'h0);
    chk("overflow_sticky", {31'h0, overflow}, 32'h1);

    // Simultaneous write and pop at level 3, then 2*DEPTH transfers
    wr(8'h71);
    wr(8'h72);
    wr(8'h73);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      wr_en     = 1'b1;
      wr_data   = 8'h40 + 8'(i);
      baud_tick = 1'b1;
      exp_q.push_back(wr_data);
      m_lvl++;
      cyc();
      wr_en     = 1'b0;
      baud_tick = 1'b0;
      chk("simul_level", {28'h0, level}, 32'd3);
      cyc();
      tick();
      done();
    end
    for (int i = 0; i < 3; i++) frame();
    chk("wrap_empty", {31'h0, empty}, 32'h1);
    chk("wrap_queue_drained", exp_q.size(), 32'd0);

    // Reset mid-SEND
    wr(8'hE1);
    wr(8'hE2);
    tick();
    chk("rst_mid_in_send", {31'h0, tx_en}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx_en_async", {31'h0, tx_en},    32'h0);
    chk("rst_mid_level",       {28'h0, level},    32'd0);
    chk("rst_mid_overflow",    {31'h0, overflow}, 32'h0);
    chk("rst_mid_busy",        {31'h0, busy},     32'h0);
    exp_q.delete();
    m_lvl = 0;
    cyc();
    reset_n = 1'b1;
    cyc();
    tick();
    tick();
    chk("rst_no_stale_launch", {31'h0, tx_en}, 32'h0);
    wr(8'h5A);
    frame();
    chk("final_empty", {31'h0, empty}, 32'h1);
    chk("final_queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
